// File: rtl/uart_rx_8bytes.sv
// ---------------------------------------------------------------------------
// uart_rx_8bytes
//
// 8N1 UART receiver that assembles eight consecutive good bytes into one
// 64-bit word. The word is published on op_data with a one-cycle op_flag
// pulse. A partial word is dropped if the line sits idle for TIMEOUT_CYC
// cycles, or if any frame has a bad stop bit.
//
// Parameters
//   BAUD_CNT_MAX : clk cycles per UART bit
//   TIMEOUT_CYC  : idle cycles after which a partial word is discarded
//
// Ports
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   rx        : asynchronous serial input, idle high
//   op_data   : last complete word, byte k in bits [8k+7:8k]
//   op_flag   : one-cycle pulse, op_data newly valid
//   frame_err : one-cycle pulse on a stop-bit error
// ---------------------------------------------------------------------------
module uart_rx_8bytes #(
    parameter int BAUD_CNT_MAX = 5208,
    parameter int TIMEOUT_CYC  = 52080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [63:0] op_data,
    output logic        op_flag,
    output logic        frame_err
);

    localparam int BW = $clog2(BAUD_CNT_MAX);
    localparam int IW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [BW-1:0] SAMPLE_PT    = BW'(BAUD_CNT_MAX / 2);
    localparam logic [BW-1:0] BAUD_LAST    = BW'(BAUD_CNT_MAX - 1);
    localparam logic [IW-1:0] TIMEOUT_LAST = IW'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_START = 4'b0010,
        ST_DATA  = 4'b0100,
        ST_STOP  = 4'b1000
    } state_t;

    // Synchroniser and edge-detect flops. They reset to 1 (line idle), so
    // reset release never looks like a start bit.
    logic rx_meta_r;
    logic rx_sync_r;
    logic rx_prev_r;

    state_t          state_r;
    logic [BW-1:0]   baud_cnt_r;
    logic [IW-1:0]   idle_cnt_r;
    logic [2:0]      bit_idx_r;
    logic [2:0]      byte_cnt_r;
    logic [7:0]      shift_r;
    // Slots 0..6 of the word in progress. Slot 7 is never stored, because
    // the final byte goes straight from shift_r into op_data.
    logic [6:0][7:0] word_r;
    logic [63:0]     op_data_r;
    logic            op_flag_r;
    logic            frame_err_r;

    logic            fall_s;
    logic            sample_s;
    logic [BW-1:0]   baud_next_s;

    assign fall_s      = rx_prev_r & ~rx_sync_r;
    assign sample_s    = (baud_cnt_r == SAMPLE_PT);
    assign baud_next_s = (baud_cnt_r == BAUD_LAST) ? {BW{1'b0}} : (baud_cnt_r + BW'(1));

    assign op_data   = op_data_r;
    assign op_flag   = op_flag_r;
    assign frame_err = frame_err_r;

    // Two-flop synchroniser for rx, plus a third flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Receive FSM: bit timing, byte assembly, word assembly, idle timeout and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            baud_cnt_r  <= {BW{1'b0}};
            idle_cnt_r  <= {IW{1'b0}};
            bit_idx_r   <= 3'd0;
            byte_cnt_r  <= 3'd0;
            shift_r     <= 8'd0;
            word_r      <= 56'd0;
            op_data_r   <= 64'd0;
            op_flag_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            // Output pulses default low, so each one lasts exactly one cycle.
            op_flag_r   <= 1'b0;
            frame_err_r <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    // Holding the counter at zero means START always begins
                    // with a cleared counter.
                    baud_cnt_r <= {BW{1'b0}};
                    if (fall_s) begin
                        state_r    <= ST_START;
                        idle_cnt_r <= {IW{1'b0}};
                    end else if (byte_cnt_r != 3'd0) begin
                        // A partial word is pending. Drop it if the line stays
                        // quiet for too long.
                        if (idle_cnt_r == TIMEOUT_LAST) begin
                            byte_cnt_r <= 3'd0;
                            idle_cnt_r <= {IW{1'b0}};
                        end else begin
                            idle_cnt_r <= idle_cnt_r + IW'(1);
                        end
                    end else begin
                        idle_cnt_r <= {IW{1'b0}};
                    end
                end

                ST_START: begin
                    baud_cnt_r <= baud_next_s;
                    if (sample_s) begin
                        // The line must still be low at mid-bit. Anything
                        // shorter than half a bit is a glitch and is ignored.
                        if (!rx_sync_r) begin
                            state_r   <= ST_DATA;
                            bit_idx_r <= 3'd0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end

                ST_DATA: begin
                    baud_cnt_r <= baud_next_s;
                    if (sample_s) begin
                        // LSB first: each new bit enters at the top and moves
                        // down as later bits arrive.
                        shift_r   <= {rx_sync_r, shift_r[7:1]};
                        bit_idx_r <= bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end
                    end
                end

                ST_STOP: begin
                    baud_cnt_r <= baud_next_s;
                    if (sample_s) begin
                        // Return to IDLE at mid stop bit, so the receiver is
                        // ready for a start bit that immediately follows.
                        state_r <= ST_IDLE;
                        if (rx_sync_r) begin
                            if (byte_cnt_r == 3'd7) begin
                                op_data_r  <= {shift_r, word_r};
                                op_flag_r  <= 1'b1;
                                byte_cnt_r <= 3'd0;
                            end else begin
                                word_r[byte_cnt_r] <= shift_r;
                                byte_cnt_r         <= byte_cnt_r + 3'd1;
                            end
                        end else begin
                            frame_err_r <= 1'b1;
                            byte_cnt_r  <= 3'd0;
                        end
                    end
                end

                default: begin
                    state_r    <= ST_IDLE;
                    baud_cnt_r <= {BW{1'b0}};
                    idle_cnt_r <= {IW{1'b0}};
                    byte_cnt_r <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_8bytes.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_8bytes
//
// Scoreboard bench for uart_rx_8bytes. It uses short bit and timeout
// parameters. The stimulus pushes each expected pulse (word or frame error)
// into a queue. A negedge monitor pops an entry and compares it whenever
// op_flag or frame_err is high.
// ---------------------------------------------------------------------------
module tb_uart_rx_8bytes;

    localparam int BAUD    = 16;
    localparam int TIMEOUT = 160;

    typedef struct {
        logic        is_err;
        logic [63:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic [63:0] op_data;
    logic        op_flag;
    logic        frame_err;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests;
    int   fails;

    uart_rx_8bytes #(
        .BAUD_CNT_MAX(BAUD),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .op_data  (op_data),
        .op_flag  (op_flag),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every output pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && (op_flag || frame_err)) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: got flag=%0b err=%0b data=%h, required no pulse",
                         op_flag, frame_err, op_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_err) begin
                    if (!(frame_err && !op_flag)) begin
                        fails++;
                        $display("FAIL frame_err_pulse: got flag=%0b err=%0b, required flag=0 err=1",
                                 op_flag, frame_err);
                    end
                end else if (!(op_flag && !frame_err && op_data == mon_e.data)) begin
                    fails++;
                    $display("FAIL word: got flag=%0b err=%0b data=%h, required flag=1 err=0 data=%h",
                             op_flag, frame_err, op_data, mon_e.data);
                end
            end
        end
    end

    task automatic push_word(input logic [63:0] d);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = 64'd0;
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (BAUD) @(posedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    // One 8N1 frame. A bad stop bit is followed by one idle bit, so the
    // next start bit produces a falling edge.
    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_v);
        if (!stop_v) send_bit(1'b1);
    endtask

    task automatic check_outputs_reset(input string name);
        tests++;
        if (op_data !== 64'd0 || op_flag !== 1'b0 || frame_err !== 1'b0) begin
            fails++;
            $display("FAIL %s: got data=%h flag=%b err=%b, required data=0 flag=0 err=0",
                     name, op_data, op_flag, frame_err);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_reset("reset_state");
        rst_n = 1'b1;
        idle(10);

        // Bytes 0x01..0x08 back to back form one word.
        for (int i = 0; i < 8; i++) begin
            if (i == 7) push_word(64'h0807060504030201);
            send_byte(8'(i + 1), 1'b1);
        end
        idle(2 * TIMEOUT);

        // Byte 3 has a bad stop bit. The partial word is dropped and bytes
        // 4..7 start a new partial word, which the idle gap then times out.
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                push_err();
                send_byte(8'h5A, 1'b0);
            end else begin
                send_byte(8'(8'h30 + i), 1'b1);
            end
        end
        idle(2 * TIMEOUT);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) push_word(64'hA7A6A5A4A3A2A1A0);
            send_byte(8'(8'hA0 + i), 1'b1);
        end
        idle(20);

        // op_data holds the last word while a new partial word is in progress.
        send_byte(8'hEE, 1'b1);
        send_byte(8'hEF, 1'b1);
        @(posedge clk); #1;
        tests++;
        if (op_data !== 64'hA7A6A5A4A3A2A1A0) begin
            fails++;
            $display("FAIL hold_word: got %h, required %h", op_data, 64'hA7A6A5A4A3A2A1A0);
        end
        idle(2 * TIMEOUT);

        // A glitch shorter than half a bit mid-word leaves the byte count intact.
        for (int i = 0; i < 4; i++) send_byte(8'(8'h40 + i), 1'b1);
        idle(20);
        rx = 1'b0;
        repeat (5) @(posedge clk);
        idle(40);
        for (int i = 4; i < 8; i++) begin
            if (i == 7) push_word(64'h4746454443424140);
            send_byte(8'(8'h40 + i), 1'b1);
        end
        idle(2 * TIMEOUT);

        // An idle gap shorter than the timeout keeps the partial word.
        for (int i = 0; i < 3; i++) send_byte(8'(8'h60 + i), 1'b1);
        idle(100);
        for (int i = 3; i < 8; i++) begin
            if (i == 7) push_word(64'h6766656463626160);
            send_byte(8'(8'h60 + i), 1'b1);
        end
        idle(20);

        // An idle gap longer than the timeout discards three pending bytes.
        for (int i = 0; i < 3; i++) send_byte(8'(8'h70 + i), 1'b1);
        idle(300);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) push_word(64'h1817161514131211);
            send_byte(8'(8'h11 + i), 1'b1);
        end
        idle(20);

        // Reset during the data bits of byte 5 abandons the frame and the
        // partial word.
        for (int i = 0; i < 4; i++) send_byte(8'(8'h90 + i), 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst_n = 1'b0;
        #1;
        check_outputs_reset("reset_mid_frame");
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_outputs_reset("reset_held");
        rst_n = 1'b1;
        idle(20);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) push_word(64'hC7C6C5C4C3C2C1C0);
            send_byte(8'(8'hC0 + i), 1'b1);
        end
        idle(40);

        // Every expected pulse must have been seen.
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_expectations: got %0d left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
